// File: rtl/fir_operand_feeder.sv
// Operand feeder for the FIR ALU: circular sample delay line plus coefficient bank, one (x[n-k], h[k]) pair per tap.
// Optional build macro FIR_ZERO_SKIP_EN: taps with a zero coefficient are skipped.
module fir_operand_feeder #(
    parameter int DATA_W = 16,
    parameter int NTAPS  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [DATA_W-1:0] coef_wdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [1:0]        op_sel,
    output logic [ADDR_W-1:0] m_tap,
    output logic              m_last,
    output logic              busy
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] delay_line [NTAPS];
    logic signed [DATA_W-1:0] coef       [NTAPS];
    logic signed [DATA_W-1:0] coef_eff   [NTAPS];
    logic [ADDR_W-1:0]        wr_ptr, head, hd_sel, rd_idx;
    logic [ADDR_W-1:0]        base_p0, tap_p0;
    logic                     last_p0;
    logic signed [DATA_W-1:0] a_p0, b_p0;
    logic                     accept, advance;
`ifdef FIR_ZERO_SKIP_EN
    logic                     found;
`endif

    assign accept  = (state == IDLE) && s_valid && s_ready;
    assign advance = (state == EMIT) && m_valid && m_ready;

    // Write-first view of the coefficient bank, so a write landing on the loading tap is seen.
    always_comb begin
        for (int i = 0; i < NTAPS; i++)
            coef_eff[i] = (coef_we && coef_addr == ADDR_W'(i)) ? coef_wdata : coef[i];
    end

    // Stage p0: choose the next tap and fetch its operands.
    always_comb begin
        base_p0 = (state == IDLE) ? '0 : m_tap + ADDR_W'(1);
`ifdef FIR_ZERO_SKIP_EN
        // With no nonzero tap left, fall back to a zero-coefficient tap flagged last
        // so downstream still sees the end of the burst.
        found   = 1'b0;
        tap_p0  = (state == IDLE) ? '0 : ADDR_W'(NTAPS - 1);
        last_p0 = 1'b1;
        for (int i = 0; i < NTAPS; i++) begin
            if (!found && ADDR_W'(i) >= base_p0 && coef_eff[i] != '0) begin
                tap_p0 = ADDR_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NTAPS; i++) begin
            if (found && ADDR_W'(i) > tap_p0 && coef_eff[i] != '0)
                last_p0 = 1'b0;
        end
`else
        tap_p0  = base_p0;
        last_p0 = (base_p0 == ADDR_W'(NTAPS - 1));
`endif
        // NTAPS is a power of two, so the ADDR_W subtraction wraps mod NTAPS.
        hd_sel = (state == IDLE) ? wr_ptr : head;
        rd_idx = hd_sel - tap_p0;
        a_p0   = (state == IDLE && tap_p0 == '0) ? s_data : delay_line[rd_idx];
        b_p0   = coef_eff[tap_p0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                delay_line[i] <= '0;
                coef[i]       <= '0;
            end
        end else begin
            if (accept)
                delay_line[wr_ptr] <= s_data;
            if (coef_we)
                coef[coef_addr] <= coef_wdata;
        end
    end

    // Stage p1: registered operand pair and handshake control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            a       <= '0;
            b       <= '0;
            op_sel  <= 2'b00;
            m_tap   <= '0;
            wr_ptr  <= '0;
            head    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        head    <= wr_ptr;
                        wr_ptr  <= wr_ptr + ADDR_W'(1);
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= EMIT;
                        m_valid <= 1'b1;
                        a       <= a_p0;
                        b       <= b_p0;
                        op_sel  <= 2'b01;
                        m_tap   <= tap_p0;
                        m_last  <= last_p0;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                EMIT: begin
                    if (advance) begin
                        if (m_last) begin
                            state   <= IDLE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            op_sel  <= 2'b00;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                        end else begin
                            a      <= a_p0;
                            b      <= b_p0;
                            m_tap  <= tap_p0;
                            m_last <= last_p0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_operand_feeder.sv
// Directed bench for fir_operand_feeder: reset state, burst contents, delay-line wrap, stall, coef writes, mid-burst reset.
`timescale 1ns/1ps
module tb_fir_operand_feeder;
    localparam int DW = 16;
    localparam int NT = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_wdata;
    logic          m_valid, m_ready;
    logic [DW-1:0] a, b;
    logic [1:0]    op_sel;
    logic [AW-1:0] m_tap;
    logic          m_last, busy;

    always #5 clk = ~clk;

    fir_operand_feeder #(.DATA_W(DW), .NTAPS(NT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .m_valid(m_valid), .m_ready(m_ready),
        .a(a), .b(b), .op_sel(op_sel), .m_tap(m_tap), .m_last(m_last), .busy(busy)
    );

    typedef struct {
        int          id;
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
    } vec_t;

    vec_t          vecs[$];
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] cap_a   [256];
    logic [DW-1:0] cap_b   [256];
    logic [AW-1:0] cap_tap [256];
    logic          cap_last[256];
    logic [1:0]    cap_op  [256];
    int            cap_n, cap_cycles;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic write_ramp();
        for (int k = 0; k < NT; k++) begin
            coef_we    = 1'b1;
            coef_addr  = AW'(k);
            coef_wdata = DW'(k + 1);
            tick();
        end
        coef_we = 1'b0;
    endtask

    task automatic write_coef(input int k, input int v);
        coef_we    = 1'b1;
        coef_addr  = AW'(k);
        coef_wdata = DW'(v);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic send_sample(input logic [DW-1:0] x);
        int waitc;
        waitc = 0;
        while (!s_ready && waitc < 200) begin
            tick();
            waitc++;
        end
        check("s_ready_wait", s_ready, 1);
        s_valid = 1'b1;
        s_data  = x;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        check("first_pair_latency", m_valid, 1);
    endtask

    // Collects one whole burst; optionally stalls 3 cycles at k=10 while writing coef[20] and coef[10].
    task automatic run_burst(input logic [DW-1:0] x, input bit do_stall);
        bit          done, stalled;
        int          nlast, nbadop;
        logic [63:0] held;
        send_sample(x);
        cap_n = 0; cap_cycles = 0; done = 0; stalled = 0;
        while (!done && cap_cycles < 300) begin
            if (!m_valid) break;
            if (do_stall && !stalled && m_tap == AW'(10)) begin
                m_ready = 1'b0;
                held = {25'd0, m_valid, a, b, m_tap};
                for (int s = 0; s < 3; s++) begin
                    coef_we    = (s < 2);
                    coef_addr  = (s == 0) ? 6'd20 : 6'd10;
                    coef_wdata = (s == 0) ? 16'd7 : 16'd999;
                    tick();
                    cap_cycles++;
                    check("stall_hold", {25'd0, m_valid, a, b, m_tap}, held);
                end
                coef_we = 1'b0;
                m_ready = 1'b1;
                stalled = 1;
            end
            if (cap_n < 256) begin
                cap_a[cap_n]    = a;
                cap_b[cap_n]    = b;
                cap_tap[cap_n]  = m_tap;
                cap_last[cap_n] = m_last;
                cap_op[cap_n]   = op_sel;
            end
            cap_n++;
            if (m_last) done = 1;
            tick();
            cap_cycles++;
        end
        nlast = 0; nbadop = 0;
        for (int i = 0; i < cap_n && i < 256; i++) begin
            if (cap_last[i]) nlast++;
            if (cap_op[i] != 2'b01) nbadop++;
        end
        check("burst_done", done, 1);
        check("burst_last_count", nlast, 1);
        check("burst_op_sel", nbadop, 0);
        check("burst_cycles", cap_cycles, cap_n + (do_stall ? 3 : 0));
        check("burst_end_m_valid", m_valid, 0);
        check("burst_end_s_ready", s_ready, 1);
    endtask

    task automatic apply_vecs(input int id);
        foreach (vecs[i]) begin
            if (vecs[i].id == id) begin
                check($sformatf("vec%0d_k%0d_a", id, vecs[i].k), cap_a[vecs[i].k], vecs[i].a);
                check($sformatf("vec%0d_k%0d_b", id, vecs[i].k), cap_b[vecs[i].k], vecs[i].b);
                check($sformatf("vec%0d_k%0d_tap", id, vecs[i].k), cap_tap[vecs[i].k], vecs[i].k);
                check($sformatf("vec%0d_k%0d_last", id, vecs[i].k), cap_last[vecs[i].k], vecs[i].last);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waitc, bad;
        // id0: sample 5 after reset; id1: third of samples 1,2,3; id2: 67th sample; id3: stalled burst; id4: after mid-burst reset
        vecs.push_back('{0, 0,  16'd5,   16'd1,  1'b0});
        vecs.push_back('{0, 1,  16'd0,   16'd2,  1'b0});
        vecs.push_back('{0, 10, 16'd0,   16'd11, 1'b0});
        vecs.push_back('{0, 63, 16'd0,   16'd64, 1'b1});
        vecs.push_back('{1, 0,  16'd3,   16'd1,  1'b0});
        vecs.push_back('{1, 1,  16'd2,   16'd2,  1'b0});
        vecs.push_back('{1, 2,  16'd1,   16'd3,  1'b0});
        vecs.push_back('{1, 3,  16'd0,   16'd4,  1'b0});
        vecs.push_back('{2, 0,  16'd67,  16'd1,  1'b0});
        vecs.push_back('{2, 2,  16'd65,  16'd3,  1'b0});
        vecs.push_back('{2, 3,  16'd64,  16'd4,  1'b0});
        vecs.push_back('{2, 63, 16'd4,   16'd64, 1'b1});
        vecs.push_back('{3, 0,  16'd100, 16'd1,  1'b0});
        vecs.push_back('{3, 10, 16'd58,  16'd11, 1'b0});
        vecs.push_back('{3, 20, 16'd48,  16'd7,  1'b0});
        vecs.push_back('{3, 63, 16'd5,   16'd64, 1'b1});
        vecs.push_back('{4, 0,  16'd9,   16'd1,  1'b0});
        vecs.push_back('{4, 1,  16'd0,   16'd2,  1'b0});
        vecs.push_back('{4, 63, 16'd0,   16'd64, 1'b1});

        s_valid = 1'b0; s_data = '0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; m_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_m_valid", m_valid, 0);
        check("post_rst_a", a, 0);
        check("post_rst_b", b, 0);
        check("post_rst_op_sel", op_sel, 0);
        check("post_rst_m_tap", m_tap, 0);
        check("post_rst_m_last", m_last, 0);

        write_ramp();
        run_burst(16'd5, 0);
        check("burst5_pairs", cap_n, NT);
        apply_vecs(0);

        rst = 1'b1; tick(); rst = 1'b0; tick();
        write_ramp();
        run_burst(16'd1, 0);
        run_burst(16'd2, 0);
        run_burst(16'd3, 0);
        apply_vecs(1);
        for (int s = 4; s <= 67; s++) run_burst(DW'(s), 0);
        apply_vecs(2);

        run_burst(16'd100, 1);
        check("stall_pairs", cap_n, NT);
        bad = 0;
        for (int i = 0; i < NT; i++) if (cap_tap[i] != AW'(i)) bad++;
        check("stall_tap_sequence", bad, 0);
        apply_vecs(3);

        send_sample(16'd200);
        waitc = 0;
        while (m_tap != AW'(30) && waitc < 100) begin
            tick();
            waitc++;
        end
        check("reached_k30", m_tap, 30);
        rst = 1'b1;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_m_last", m_last, 0);
        check("midrst_op_sel", op_sel, 0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_s_ready_back", s_ready, 1);
        write_ramp();
        run_burst(16'd9, 0);
        check("post_midrst_pairs", cap_n, NT);
        apply_vecs(4);

`ifdef FIR_ZERO_SKIP_EN
        rst = 1'b1; tick(); rst = 1'b0; tick();
        write_coef(3, 5);
        write_coef(9, 6);
        run_burst(16'd11, 0);
        check("skip_pairs", cap_n, 2);
        check("skip_tap0", cap_tap[0], 3);
        check("skip_b0", cap_b[0], 5);
        check("skip_last0", cap_last[0], 0);
        check("skip_tap1", cap_tap[1], 9);
        check("skip_b1", cap_b[1], 6);
        check("skip_last1", cap_last[1], 1);
        write_coef(3, 0);
        write_coef(9, 0);
        run_burst(16'd12, 0);
        check("allzero_pairs", cap_n, 1);
        check("allzero_tap", cap_tap[0], 0);
        check("allzero_a", cap_a[0], 12);
        check("allzero_b", cap_b[0], 0);
        check("allzero_last", cap_last[0], 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
